// File: rtl/cond_exec_stage.sv
// ID/EX control pipeline register with NZCV flag register and condition-check unit.
// E-stage side-effecting controls are gated by the condition result and by stall.
module cond_exec_stage #(
    parameter int         ALUCTRL_W = 4,
    parameter logic [3:0] FLAGS_RST = 4'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_e,
    input  logic                 stall_e,
    input  logic                 PCSrcD,
    input  logic                 BranchD,
    input  logic                 RegWriteD,
    input  logic                 MemWriteD,
    input  logic                 MemtoRegD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic                 ALUSrcD,
    input  logic [1:0]           FlagWriteD,
    input  logic [3:0]           CondD,
    input  logic [3:0]           ALUFlags,
    output logic                 PCSrcE,
    output logic                 BranchTakenE,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 MemtoRegE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 CondExE,
    output logic [3:0]           Flags,
    output logic                 Z_FLAG
);

    localparam logic [3:0] COND_AL = 4'hE;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic pass;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    pass = z;
            4'h1:    pass = !z;
            4'h2:    pass = c;
            4'h3:    pass = !c;
            4'h4:    pass = n;
            4'h5:    pass = !n;
            4'h6:    pass = v;
            4'h7:    pass = !v;
            4'h8:    pass = c & !z;
            4'h9:    pass = !c | z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = !z & (n == v);
            4'hD:    pass = z | (n != v);
            4'hE:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    logic                 pc_src_p1;
    logic                 branch_p1;
    logic                 reg_write_p1;
    logic                 mem_write_p1;
    logic                 mem_to_reg_p1;
    logic [ALUCTRL_W-1:0] alu_ctrl_p1;
    logic                 alu_src_p1;
    logic [1:0]           flag_write_p1;
    logic [3:0]           cond_p1;
    logic [3:0]           flags_q;
    logic                 cond_ex;
    logic                 issue;

    // D -> E boundary: flush inserts a bubble (cond AL so it reads as a clean no-op)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_src_p1     <= 1'b0;
            branch_p1     <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            alu_ctrl_p1   <= '0;
            alu_src_p1    <= 1'b0;
            flag_write_p1 <= 2'b00;
            cond_p1       <= COND_AL;
        end else if (flush_e) begin
            pc_src_p1     <= 1'b0;
            branch_p1     <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            alu_ctrl_p1   <= '0;
            alu_src_p1    <= 1'b0;
            flag_write_p1 <= 2'b00;
            cond_p1       <= COND_AL;
        end else if (!stall_e) begin
            pc_src_p1     <= PCSrcD;
            branch_p1     <= BranchD;
            reg_write_p1  <= RegWriteD;
            mem_write_p1  <= MemWriteD;
            mem_to_reg_p1 <= MemtoRegD;
            alu_ctrl_p1   <= ALUControlD;
            alu_src_p1    <= ALUSrcD;
            flag_write_p1 <= FlagWriteD;
            cond_p1       <= CondD;
        end
    end

    assign cond_ex = cond_pass(cond_p1, flags_q);
    assign issue   = cond_ex & !stall_e;

    // Flag write belongs to the instruction leaving E, so a same-edge flush does not cancel it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= FLAGS_RST;
        end else if (issue) begin
            if (flag_write_p1[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (flag_write_p1[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // E -> M boundary: stalled E presents a bubble downstream
    assign PCSrcE       = pc_src_p1 & issue;
    assign BranchTakenE = branch_p1 & issue;
    assign RegWriteE    = reg_write_p1 & issue;
    assign MemWriteE    = mem_write_p1 & issue;
    assign MemtoRegE    = mem_to_reg_p1;
    assign ALUControlE  = alu_ctrl_p1;
    assign ALUSrcE      = alu_src_p1;
    assign CondExE      = cond_ex;
    assign Flags        = flags_q;
    assign Z_FLAG       = flags_q[2];

endmodule
